parking_gate_ctrl: RTL and testbench
====================================

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 The block SHALL provide parameter GATE_TIMEOUT, default 30: maximum cycles a barrier stays open waiting for the car to pass.
REQ-002 The block SHALL provide parameter DENY_HOLD, default 3: cycles entry_denied stays asserted after a refusal.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports entry_req / exit_req  input  1  level requests from the entry and exit lane sensors.
REQ-006 The block SHALL have ports entry_is_uni / exit_is_uni  input  1  university-car tag for the requesting car.
REQ-007 The block SHALL have ports entry_passed / exit_passed  input  1  car-cleared-barrier sensors.
REQ-008 The block SHALL have ports uni_is_vacated_space / is_vacated_space  input  1  vacancy flags from the parking control unit.
REQ-009 The block SHALL have ports car_entered / car_exited  output  1  one-cycle event pulses to the control unit.
REQ-010 The block SHALL have ports is_uni_car_entered / is_uni_car_exited  output  1  qualifiers for those pulses.
REQ-011 The block SHALL have ports entry_gate_open / exit_gate_open  output  1  barrier drive; entry_denied  output  1  refusal lamp.
REQ-012 The block SHALL have port denied_count  output  16  number of refused entries since reset.

Function
REQ-013 The entry FSM SHALL use states E_IDLE, E_CHECK, E_OPEN, E_NOTIFY, E_DENY; the exit FSM SHALL use X_IDLE, X_OPEN, X_NOTIFY; both run concurrently and independently.
REQ-014 In E_IDLE with entry_req=1, the FSM SHALL latch entry_is_uni and go to E_CHECK.
REQ-015 In E_CHECK, the FSM SHALL sample uni_is_vacated_space if the latched tag is 1, else is_vacated_space; flag=1 -> E_OPEN, flag=0 -> E_DENY.
REQ-016 In E_OPEN, entry_gate_open SHALL be 1, is_uni_car_entered SHALL equal the latched tag, and a 16-bit wait counter SHALL increment each cycle from 0.
REQ-017 In E_OPEN, entry_passed=1 SHALL move the FSM to E_NOTIFY, taking priority over timeout in the same cycle.
REQ-018 In E_OPEN, a wait counter of GATE_TIMEOUT-1 with entry_passed=0 SHALL return the FSM to E_IDLE with no car_entered pulse.
REQ-019 E_NOTIFY SHALL last exactly one cycle with car_entered=1, entry_gate_open=0, and is_uni_car_entered held; then E_IDLE.
REQ-020 is_uni_car_entered SHALL be stable from the cycle before car_entered rises until after it falls, and 0 in E_IDLE.
REQ-021 E_DENY SHALL assert entry_denied for DENY_HOLD cycles, increment denied_count once (saturating at 65535), then return to E_IDLE.
REQ-022 The exit FSM SHALL never refuse: X_IDLE with exit_req=1 SHALL latch exit_is_uni and go to X_OPEN (exit_gate_open=1, is_uni_car_exited=tag).
REQ-023 In X_OPEN, exit_passed SHALL lead to X_NOTIFY and timeout SHALL lead to X_IDLE, with the same counter and priority rules as entry.
REQ-024 X_NOTIFY SHALL produce a one-cycle car_exited pulse with the same qualifier-stability rules as entry.
REQ-025 Pulses SHALL be separated by at least one low cycle, because every transaction returns through IDLE.
REQ-026 A request held high SHALL start a new transaction immediately after IDLE is re-entered.
REQ-027 car_entered and car_exited MAY be high in the same cycle.

Reset
REQ-028 While rst=1, both FSMs SHALL be in IDLE, all outputs SHALL be 0, counters and latched tags SHALL be 0, and denied_count SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL close gates and drop pulses immediately (asynchronously), and no event SHALL be emitted afterwards for the aborted transaction.

Verification
REQ-030 Entry, regular car: is_vacated_space=1, entry_req at cycle 0, entry_passed at cycle 5 -> entry_gate_open cycles 2-5, car_entered=1 at cycle 6 only, is_uni_car_entered=0.
REQ-031 Entry, uni car refused: uni_is_vacated_space=0, entry_is_uni=1 -> entry_denied high 3 cycles, denied_count=1, no gate, no pulse.
REQ-032 Entry timeout: vacancy=1, entry_passed never asserted -> gate open exactly 30 cycles, then closed, no car_entered pulse.
REQ-033 Concurrent events: entry and exit requests together, both passed at cycle 4 -> car_entered and car_exited both high at cycle 5, with correct qualifiers.
REQ-034 Reset mid-operation: rst pulsed while exit_gate_open=1 -> exit_gate_open=0 within the same cycle, no car_exited pulse, clean transaction afterwards.
REQ-035 Saturation: force 65536 refusals -> denied_count holds at 65535.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// Parking barrier controller with independent entry and exit lanes.
// The entry lane checks vacancy before opening and refuses when the lot is
// full. The exit lane always opens. Each completed passage produces a
// one-cycle event pulse with a university-car qualifier.
module parking_gate_ctrl #(
  parameter int GATE_TIMEOUT = 30,
  parameter int DENY_HOLD    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        entry_req,
  input  logic        exit_req,
  input  logic        entry_is_uni,
  input  logic        exit_is_uni,
  input  logic        entry_passed,
  input  logic        exit_passed,
  input  logic        uni_is_vacated_space,
  input  logic        is_vacated_space,
  output logic        car_entered,
  output logic        car_exited,
  output logic        is_uni_car_entered,
  output logic        is_uni_car_exited,
  output logic        entry_gate_open,
  output logic        exit_gate_open,
  output logic        entry_denied,
  output logic [15:0] denied_count
);

  typedef enum logic [2:0] {
    E_IDLE,
    E_CHECK,
    E_OPEN,
    E_NOTIFY,
    E_DENY
  } entry_state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_OPEN,
    X_NOTIFY
  } exit_state_t;

  // Last counter value of an open window / refusal hold; the counter starts
  // at 0 on the first cycle, so GATE_TIMEOUT cycles end at GATE_TIMEOUT-1.
  localparam logic [15:0] GATE_LAST = 16'(GATE_TIMEOUT - 1);
  localparam logic [15:0] DENY_LAST = 16'(DENY_HOLD - 1);
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  entry_state_t e_state_reg, e_state_next;
  logic         e_tag_reg,   e_tag_next;
  logic [15:0]  e_cnt_reg,   e_cnt_next;
  logic [15:0]  denied_count_reg, denied_count_next;

  exit_state_t  x_state_reg, x_state_next;
  logic         x_tag_reg,   x_tag_next;
  logic [15:0]  x_cnt_reg,   x_cnt_next;

  // Entry lane state, latched tag, wait counter and refusal tally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_state_reg      <= E_IDLE;
      e_tag_reg        <= 1'b0;
      e_cnt_reg        <= 16'd0;
      denied_count_reg <= 16'd0;
    end else begin
      e_state_reg      <= e_state_next;
      e_tag_reg        <= e_tag_next;
      e_cnt_reg        <= e_cnt_next;
      denied_count_reg <= denied_count_next;
    end
  end

  // Entry lane next-state and outputs; outputs decode the state only, so an
  // asynchronous reset drops the gate and pulses at once.
  always_comb begin
    e_state_next       = e_state_reg;
    e_tag_next         = e_tag_reg;
    e_cnt_next         = e_cnt_reg;
    denied_count_next  = denied_count_reg;
    entry_gate_open    = 1'b0;
    car_entered        = 1'b0;
    is_uni_car_entered = 1'b0;
    entry_denied       = 1'b0;
    case (e_state_reg)
      E_IDLE: begin
        if (entry_req) begin
          e_tag_next   = entry_is_uni;
          e_state_next = E_CHECK;
        end
      end
      E_CHECK: begin
        e_cnt_next = 16'd0;
        if (e_tag_reg ? uni_is_vacated_space : is_vacated_space) begin
          e_state_next = E_OPEN;
        end else begin
          e_state_next = E_DENY;
          if (denied_count_reg != COUNT_MAX) begin
            denied_count_next = denied_count_reg + 16'd1;
          end
        end
      end
      E_OPEN: begin
        entry_gate_open    = 1'b1;
        is_uni_car_entered = e_tag_reg;
        // A passing car wins over a timeout landing in the same cycle.
        if (entry_passed) begin
          e_state_next = E_NOTIFY;
        end else if (e_cnt_reg == GATE_LAST) begin
          e_state_next = E_IDLE;
        end else begin
          e_cnt_next = e_cnt_reg + 16'd1;
        end
      end
      E_NOTIFY: begin
        car_entered        = 1'b1;
        is_uni_car_entered = e_tag_reg;
        e_state_next       = E_IDLE;
      end
      E_DENY: begin
        entry_denied = 1'b1;
        if (e_cnt_reg == DENY_LAST) begin
          e_state_next = E_IDLE;
        end else begin
          e_cnt_next = e_cnt_reg + 16'd1;
        end
      end
      default: e_state_next = E_IDLE;
    endcase
  end

  // Exit lane state, latched tag and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_state_reg <= X_IDLE;
      x_tag_reg   <= 1'b0;
      x_cnt_reg   <= 16'd0;
    end else begin
      x_state_reg <= x_state_next;
      x_tag_reg   <= x_tag_next;
      x_cnt_reg   <= x_cnt_next;
    end
  end

  // Exit lane next-state and outputs; exits are never refused.
  always_comb begin
    x_state_next      = x_state_reg;
    x_tag_next        = x_tag_reg;
    x_cnt_next        = x_cnt_reg;
    exit_gate_open    = 1'b0;
    car_exited        = 1'b0;
    is_uni_car_exited = 1'b0;
    case (x_state_reg)
      X_IDLE: begin
        if (exit_req) begin
          x_tag_next   = exit_is_uni;
          x_cnt_next   = 16'd0;
          x_state_next = X_OPEN;
        end
      end
      X_OPEN: begin
        exit_gate_open    = 1'b1;
        is_uni_car_exited = x_tag_reg;
        if (exit_passed) begin
          x_state_next = X_NOTIFY;
        end else if (x_cnt_reg == GATE_LAST) begin
          x_state_next = X_IDLE;
        end else begin
          x_cnt_next = x_cnt_reg + 16'd1;
        end
      end
      X_NOTIFY: begin
        car_exited        = 1'b1;
        is_uni_car_exited = x_tag_reg;
        x_state_next      = X_IDLE;
      end
      default: x_state_next = X_IDLE;
    endcase
  end

  assign denied_count = denied_count_reg;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Randomized bench for parking_gate_ctrl. Expected waveforms for each lane
// are derived arithmetically from the transaction parameters (request cycle,
// vacancy, pass delay) rather than from any state machine.
module tb_parking_gate_ctrl;
  localparam int T  = 30;
  localparam int DH = 3;
  localparam int N  = T + 8;   // cycles observed per transaction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        entry_req = 1'b0, exit_req = 1'b0;
  logic        entry_is_uni = 1'b0, exit_is_uni = 1'b0;
  logic        entry_passed = 1'b0, exit_passed = 1'b0;
  logic        uni_is_vacated_space = 1'b0, is_vacated_space = 1'b0;
  logic        car_entered, car_exited;
  logic        is_uni_car_entered, is_uni_car_exited;
  logic        entry_gate_open, exit_gate_open, entry_denied;
  logic [15:0] denied_count;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = 0;

  parking_gate_ctrl #(.GATE_TIMEOUT(T), .DENY_HOLD(DH)) dut (
    .clk(clk), .rst(rst),
    .entry_req(entry_req), .exit_req(exit_req),
    .entry_is_uni(entry_is_uni), .exit_is_uni(exit_is_uni),
    .entry_passed(entry_passed), .exit_passed(exit_passed),
    .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
    .car_entered(car_entered), .car_exited(car_exited),
    .is_uni_car_entered(is_uni_car_entered), .is_uni_car_exited(is_uni_car_exited),
    .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
    .entry_denied(entry_denied), .denied_count(denied_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Entry lane: request in cycle 0, vacancy sampled in cycle 1, gate from
  // cycle 2; the car passes in cycle 2+d if d < T, else the gate times out
  // after T open cycles.
  task automatic entry_trial(input bit act, input bit u, input bit vu, input bit vr, input int d);
    bit ok   = u ? vu : vr;
    int p    = 2 + d;
    bit pass = (d < T);
    bit eg, ep, eq, ed;
    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      eg = act && ok && (j >= 2) && (pass ? (j <= p) : (j <= T + 1));
      ep = act && ok && pass && (j == p + 1);
      eq = (eg || ep) && u;
      ed = act && !ok && (j >= 2) && (j < 2 + DH);
      if (act && !ok && j == 2 && model_cnt != 65535) model_cnt++;
      check("entry_gate_open", 32'(entry_gate_open), 32'(eg));
      check("car_entered", 32'(car_entered), 32'(ep));
      check("is_uni_car_entered", 32'(is_uni_car_entered), 32'(eq));
      check("entry_denied", 32'(entry_denied), 32'(ed));
      check("denied_count", 32'(denied_count), 32'(model_cnt));
      if (j == 0) begin
        uni_is_vacated_space = vu;
        is_vacated_space     = vr;
      end
      entry_req    = act && (j == 0);
      entry_is_uni = (j == 0) ? u : 1'($urandom);
      entry_passed = act && (j == p);
    end
    entry_req    = 1'b0;
    entry_passed = 1'b0;
  endtask

  // Exit lane: request in cycle 0, gate from cycle 1, pass in cycle 1+d.
  task automatic exit_trial(input bit act, input bit u, input int d);
    int p    = 1 + d;
    bit pass = (d < T);
    bit eg, ep, eq;
    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      eg = act && (j >= 1) && (pass ? (j <= p) : (j <= T));
      ep = act && pass && (j == p + 1);
      eq = (eg || ep) && u;
      check("exit_gate_open", 32'(exit_gate_open), 32'(eg));
      check("car_exited", 32'(car_exited), 32'(ep));
      check("is_uni_car_exited", 32'(is_uni_car_exited), 32'(eq));
      exit_req    = act && (j == 0);
      exit_is_uni = (j == 0) ? u : 1'($urandom);
      exit_passed = act && (j == p);
    end
    exit_req    = 1'b0;
    exit_passed = 1'b0;
  endtask

  task automatic run_pair(input bit ea, input bit eu, input bit vu, input bit vr, input int ed,
                          input bit xa, input bit xu, input int xd);
    fork
      entry_trial(ea, eu, vu, vr, ed);
      exit_trial(xa, xu, xd);
    join
    $display("txn entry(act=%0d uni=%0d uvac=%0d vac=%0d d=%0d) exit(act=%0d uni=%0d d=%0d) denied_count=%0d",
             ea, eu, vu, vr, ed, xa, xu, xd, denied_count);
  endtask

  initial begin
    // Reset state.
    repeat (2) begin
      @(negedge clk);
      check("rst_entry_gate", 32'(entry_gate_open), 32'd0);
      check("rst_exit_gate", 32'(exit_gate_open), 32'd0);
      check("rst_pulses", 32'({car_entered, car_exited}), 32'd0);
      check("rst_quals", 32'({is_uni_car_entered, is_uni_car_exited}), 32'd0);
      check("rst_denied", 32'(entry_denied), 32'd0);
      check("rst_count", 32'(denied_count), 32'd0);
    end
    rst = 1'b0;

    // Directed cases.
    run_pair(1, 0, 0, 1, 3,     0, 0, 0);      // regular entry, pass at cycle 5
    run_pair(1, 1, 0, 1, 3,     0, 0, 0);      // uni car refused
    run_pair(1, 0, 1, 1, T + 2, 0, 0, 0);      // entry timeout
    run_pair(1, 1, 1, 0, T - 1, 1, 0, T - 1);  // pass on the last open cycle
    run_pair(1, 0, 1, 1, 0,     1, 1, 0);      // pass on the first open cycle
    run_pair(1, 1, 1, 0, 2,     1, 0, 3);      // both pulses in cycle 5
    run_pair(0, 0, 0, 0, 0,     1, 1, T + 1);  // exit timeout

    // Reset in the middle of an open exit.
    @(negedge clk);
    exit_req = 1'b1; exit_is_uni = 1'b1;
    @(negedge clk);
    exit_req = 1'b0;
    check("pre_rst_exit_gate", 32'(exit_gate_open), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_exit_gate", 32'(exit_gate_open), 32'd0);
    check("async_rst_exit_qual", 32'(is_uni_car_exited), 32'd0);
    check("async_rst_count", 32'(denied_count), 32'd0);
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    exit_passed = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      exit_passed = 1'b0;
      check("post_rst_no_exit_pulse", 32'(car_exited), 32'd0);
      check("post_rst_exit_gate", 32'(exit_gate_open), 32'd0);
    end
    run_pair(0, 0, 0, 0, 0, 1, 0, 4);

    // Randomized transactions.
    for (int k = 0; k < 40; k++) begin
      run_pair(($urandom % 4) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, T + 3)),
               ($urandom % 4) != 0, 1'($urandom), int'($urandom_range(0, T + 3)));
    end

    // Saturation of the refusal counter, preloaded near its ceiling.
    @(negedge clk);
    force dut.denied_count_reg = 16'd65533;
    @(negedge clk);
    release dut.denied_count_reg;
    model_cnt = 65533;
    @(negedge clk);
    check("preload_count", 32'(denied_count), 32'd65533);
    for (int k = 0; k < 4; k++) run_pair(1, 1, 0, 1, 0, 0, 0, 0);
    check("saturated_count", 32'(denied_count), 32'd65535);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
